// File: rtl/invert_pkg.sv
// Shared types and helpers for the bit-serial two's-complement negator.
// Holds the FSM state encoding and the word-counter width function.
package invert_pkg;

    typedef enum logic {
        PASS = 1'b0,
        FLIP = 1'b1
    } state_t;

    // Counter width for a word of n bits, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/invert_if.sv
// Serial operand/result pair of the negator.
// The producer drives x and observes y; the negator does the reverse.
interface invert_if;

    logic x;
    logic y;

    modport master (
        output x,
        input  y
    );

    modport slave (
        input  x,
        output y
    );

endinterface

// File: rtl/invert_bitcnt.sv
// Bit position counter for framed serial words.
// Flags the last bit of a word and wraps to zero on the following edge.
module invert_bitcnt
    import invert_pkg::*;
#(
    parameter int WORD_LEN = 4
) (
    input  logic t_clock,
    input  logic r,
    output logic last
);

    localparam int CW = cnt_w(WORD_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_LEN - 1);

    logic [CW-1:0] cnt;

    assign last = (cnt == LAST_IDX);

    // Count accepted bits; reset or the final bit restarts at position 0.
    always_ff @(posedge t_clock) begin
        if (r || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/invert.sv
// Bit-serial two's-complement negator, LSB first.
// Bits pass unchanged up to and including the first 1, then invert.
module invert
    import invert_pkg::*;
#(
    parameter int WORD_LEN = 0
) (
    input  logic x,
    input  logic r,
    input  logic t_clock,
    output logic y
);

    state_t state;
    logic   last;

    generate
        if (WORD_LEN > 0) begin : g_cnt
            invert_bitcnt #(
                .WORD_LEN(WORD_LEN)
            ) u_cnt (
                .t_clock(t_clock),
                .r      (r),
                .last   (last)
            );
        end else begin : g_nocnt
            assign last = 1'b0;
        end
    endgenerate

    // Word boundary (reset or last bit) beats a 1, so each word starts in PASS.
    always_ff @(posedge t_clock) begin
        if (r || last) begin
            state <= PASS;
        end else if (x === 1'b1) begin
            state <= FLIP;
        end
    end

    assign y = x ^ (state == FLIP);

endmodule

// File: tb/tb_invert.sv
// Directed-vector bench for invert, unframed and 4-bit framed instances.
// Each cycle is also checked against an arithmetic negation model.
module tb_invert;

    typedef struct {
        logic r;
        logic x;
        logic y0;
        logic y4;
    } vec_t;

    logic t_clock;
    logic r;
    int   n_pass;
    int   n_total;

    logic [63:0] acc0, acc4;
    int          pos0, pos4;

    vec_t vq[$];

    invert_if bus0 ();
    invert_if bus4 ();

    invert u_dut0 (
        .x      (bus0.x),
        .r      (r),
        .t_clock(t_clock),
        .y      (bus0.y)
    );

    invert #(
        .WORD_LEN(4)
    ) u_dut4 (
        .x      (bus4.x),
        .r      (r),
        .t_clock(t_clock),
        .y      (bus4.y)
    );

    initial t_clock = 1'b0;
    always #77 t_clock = ~t_clock;

    task automatic chk(input string name, input int idx,
                       input logic act, input logic exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: y=%b expected %b",
                     name, idx, act, exp);
        end
    endtask

    // Bit pos of the negated partial word: depends only on bits 0..pos.
    function automatic logic neg_bit(input logic [63:0] acc,
                                     input int pos, input logic xb);
        logic [63:0] a;
        logic [63:0] n;
        a = acc | ({63'b0, xb} << pos);
        n = -a;
        return n[pos];
    endfunction

    task automatic model_edge(input logic rb, input logic xb);
        if (rb) begin
            acc0 = '0;
            pos0 = 0;
            acc4 = '0;
            pos4 = 0;
        end else begin
            acc0 = acc0 | ({63'b0, xb} << pos0);
            pos0++;
            acc4 = acc4 | ({63'b0, xb} << pos4);
            pos4++;
            if (pos4 == 4) begin
                acc4 = '0;
                pos4 = 0;
            end
        end
    endtask

    task automatic apply(input int idx, input logic rb, input logic xb);
        @(posedge t_clock);
        #1;
        r = rb;
        bus0.x = xb;
        bus4.x = xb;
        @(negedge t_clock);
        chk("model0", idx, bus0.y, neg_bit(acc0, pos0, xb));
        chk("model4", idx, bus4.y, neg_bit(acc4, pos4, xb));
        model_edge(rb, xb);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        acc0 = '0;
        acc4 = '0;
        pos0 = 0;
        pos4 = 0;
        r = 1'b1;
        bus0.x = 1'b0;
        bus4.x = 1'b0;

        // r, x, y unframed, y framed(4)
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1});
        // 4 -> 12
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
        // 13 -> 3
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
        // all-zero word
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        // reset out of FLIP with x=1, held two cycles
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1});
        // back-to-back framed words 0110, 0001
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1});
        // wrap won: third framed word starts in PASS
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1});

        // first edge takes the reset driven from time 0
        @(posedge t_clock);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge t_clock);
            #1;
            r = vq[i].r;
            bus0.x = vq[i].x;
            bus4.x = vq[i].x;
            @(negedge t_clock);
            chk("vec_y0", i, bus0.y, vq[i].y0);
            chk("vec_y4", i, bus4.y, vq[i].y4);
            chk("model0", i, bus0.y, neg_bit(acc0, pos0, vq[i].x));
            chk("model4", i, bus4.y, neg_bit(acc4, pos4, vq[i].x));
            model_edge(vq[i].r, vq[i].x);
        end

        // pseudo-random words, periodic reset keeps unframed words short
        apply(100, 1'b1, 1'b0);
        for (int i = 0; i < 48; i++) begin
            apply(101 + i, (i % 16) == 15, 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
